// File: rtl/uart_tx_peripheral_if.sv
// Bus between memory_controller and the UART transmitter:
// byte stores and overflow clears in, serial line and status word out.
interface uart_tx_peripheral_if;
  logic        write_enable;
  logic [7:0]  write_data;
  logic        clear_overflow;
  logic        tx;
  logic [31:0] status;

  modport master (
    output write_enable,
    output write_data,
    output clear_overflow,
    input  tx,
    input  status
  );

  modport slave (
    input  write_enable,
    input  write_data,
    input  clear_overflow,
    output tx,
    output status
  );
endinterface

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter: stored bytes queue in a FIFO and are
// serialised back-to-back on tx; a status word reports FIFO/FSM state.
module uart_tx_peripheral #(
  parameter int CLOCKS_PER_BIT  = 16,
  parameter int FIFO_DEPTH      = 8,
  parameter int FIFO_ADDR_WIDTH = 3
) (
  input logic                  clock,
  input logic                  reset,
  uart_tx_peripheral_if.slave  bus
);

  localparam int BW = $clog2(CLOCKS_PER_BIT);
  localparam logic [BW-1:0]            BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] LEVEL_FULL = (FIFO_ADDR_WIDTH + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                     state_q;
  logic [BW-1:0]              baud_q;
  logic [2:0]                 bit_idx_q;
  logic [7:0]                 shift_q;
  logic                       tx_q;

  logic [7:0]                 mem [FIFO_DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q;
  logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   level_q;
  logic [FIFO_ADDR_WIDTH:0]   level_d;
  logic                       overflow_q;
  logic                       overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic baud_done;
  logic [7:0] head;

  assign full      = (level_q == LEVEL_FULL);
  assign empty     = (level_q == '0);
  assign push      = bus.write_enable && !full;
  assign baud_done = (baud_q == BAUD_LAST);
  // The FSM takes the head byte either from idle or on the last stop cycle.
  assign pop       = !empty && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));
  assign head      = mem[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // A dropped write outranks a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (bus.write_enable && full) begin
      overflow_d = 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.write_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tx     = tx_q;
  assign bus.status = {{(32 - 5 - FIFO_ADDR_WIDTH){1'b0}}, level_q, overflow_q,
                       (state_q != S_IDLE), full, empty};

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Randomised and directed bench for uart_tx_peripheral: a frame-timing
// reference model feeds a scoreboard that a serial decoder drains.
module tb_uart_tx_peripheral;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  uart_tx_peripheral_if bus ();

  uart_tx_peripheral #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH),
    .FIFO_ADDR_WIDTH(AW)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes waiting, bytes on the wire, and cycles left in the current frame.
  logic [7:0] pend_q[$];
  logic [7:0] exp_q[$];
  int         rem   = 0;
  logic [7:0] cur_m = 8'h00;
  bit         ovf_m = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit full_now;
    if (!rst_n) begin
      pend_q.delete();
      exp_q.delete();
      rem   = 0;
      ovf_m = 1'b0;
    end else begin
      full_now = (pend_q.size() == DEPTH);
      if (bus.write_enable && full_now) ovf_m = 1'b1;
      else if (bus.clear_overflow) ovf_m = 1'b0;
      if (pend_q.size() > 0 && (rem == 0 || rem == 1)) begin
        cur_m = pend_q.pop_front();
        exp_q.push_back(cur_m);
        rem = FRAME;
      end else if (rem > 0) begin
        rem--;
      end
      if (bus.write_enable && !full_now) pend_q.push_back(bus.write_data);
    end
  end

  function automatic logic exp_tx();
    int ph;
    int b;
    if (rem == 0) return 1'b1;
    ph = FRAME - rem;
    b  = ph / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return cur_m[b-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    s[0]        = (pend_q.size() == 0);
    s[1]        = (pend_q.size() == DEPTH);
    s[2]        = (rem != 0);
    s[3]        = ovf_m;
    s[4+AW:4]   = (AW + 1)'(pend_q.size());
    return s;
  endfunction

  // Monitor: per-cycle line/status comparison plus serial decode into the scoreboard.
  bit         in_frame = 1'b0;
  int         dcnt     = 0;
  int         frames   = 0;
  logic [7:0] dbyte    = 8'h00;

  always @(negedge clk) begin
    logic [7:0] e;
    check("tx_line", {31'b0, bus.tx}, {31'b0, exp_tx()});
    check("status", bus.status, exp_status());
    if (!rst_n) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (bus.tx == 1'b0) begin
        in_frame = 1'b1;
        dcnt     = 0;
        dbyte    = 8'h00;
      end
    end else begin
      dcnt++;
      if (dcnt == CPB / 2) check("start_bit", {31'b0, bus.tx}, 32'd0);
      if ((dcnt % CPB) == CPB / 2 && dcnt / CPB >= 1 && dcnt / CPB <= 8)
        dbyte[dcnt/CPB-1] = bus.tx;
      if (dcnt == 9 * CPB + CPB / 2) check("stop_bit", {31'b0, bus.tx}, 32'd1);
      if (dcnt == FRAME - 1) begin
        in_frame = 1'b0;
        frames++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_unexpected: decoded %h, expected no frame at %0t", dbyte, $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_byte", {24'b0, dbyte}, {24'b0, e});
          $display("frame %0d: decoded %h expected %h at %0t", frames, dbyte, e, $time);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] d, input logic clr);
    bus.write_enable   = we;
    bus.write_data     = d;
    bus.clear_overflow = clr;
    @(posedge clk);
    #1;
    bus.write_enable   = 1'b0;
    bus.clear_overflow = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.write_enable   = 1'b0;
    bus.write_data     = 8'h00;
    bus.clear_overflow = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("reset_status", bus.status, 32'h1);
    check("reset_tx", {31'b0, bus.tx}, 32'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // T1: single frame of 0x55.
    drive(1'b1, 8'h55, 1'b0);
    idle(FRAME + 4);
    check("t1_status_idle", bus.status, 32'h1);

    // T2: three contiguous frames.
    drive(1'b1, 8'hA0, 1'b0);
    drive(1'b1, 8'h0F, 1'b0);
    drive(1'b1, 8'hFF, 1'b0);
    check("t2_level_two", {28'b0, bus.status[7:4]}, 32'd2);
    idle(3 * FRAME + 4);

    // T3: overfill by one; T4: set beats clear, then a lone clear.
    for (int i = 0; i < 10; i++) drive(1'b1, 8'(i), 1'b0);
    check("t3_full", {31'b0, bus.status[1]}, 32'd1);
    check("t3_overflow", {31'b0, bus.status[3]}, 32'd1);
    drive(1'b1, 8'hEE, 1'b1);
    check("t4_set_wins", {31'b0, bus.status[3]}, 32'd1);
    idle(5);
    drive(1'b0, 8'h00, 1'b1);
    check("t4_cleared", {31'b0, bus.status[3]}, 32'd0);
    idle(9 * FRAME + 10);

    // T5: reset in the middle of the first data bits.
    drive(1'b1, 8'h3C, 1'b0);
    drive(1'b1, 8'hC3, 1'b0);
    drive(1'b1, 8'h99, 1'b0);
    idle(3 * CPB);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tx_high", {31'b0, bus.tx}, 32'd1);
    check("t5_status", bus.status, 32'h1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(100);

    // T6: second write landing around the final stop cycle.
    for (int off = FRAME - 1; off <= FRAME + 2; off++) begin
      drive(1'b1, 8'($urandom), 1'b0);
      idle(off - 1);
      drive(1'b1, 8'($urandom), 1'b0);
      idle(2 * FRAME + 5);
    end

    // Random traffic, including overflow and clear pulses.
    repeat (600) drive($urandom_range(0, 9) == 0, 8'($urandom), $urandom_range(0, 29) == 0);
    idle(9 * FRAME + 20);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("final_status_idle", bus.status, {27'b0, 1'b0, ovf_m, 3'b001});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
